multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for a multicycle MIPS-style datapath. It sequences fetch,
//   decode, memory, ALU, branch and jump phases. Datapath controls are driven
//   combinationally from the current state and the instruction fields. A wait
//   counter bounds every memory handshake and reports a bus error when the
//   memory does not answer in time.
//
// Parameters
//   MEM_TIMEOUT  maximum wait cycles for mem_ready in a memory state (0 = off)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   opcode, funct           IR[31:26], IR[5:0]
//   zero                    ALU zero flag
//   mem_ready               memory completes the current request this cycle
//   pc_we, ir_we, reg_we    write enables
//   mem_req, mem_we, iord   memory request / write / address select
//   ext_sel, alu_src_a      immediate extension / ALU A select
//   alu_src_b, pc_src       ALU B select / PC source select
//   reg_dst, mem_to_reg     register-file destination / write-data select
//   alu_op                  ALU operation
//   illegal, bus_error      single-cycle fault pulses
//   state                   current state code
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_REX    = 4'd6,  S_ALUWB  = 4'd7,  S_IEX    = 4'd8,
                         S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JR     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010,
                         OP_JAL   = 6'b000011, OP_BEQ  = 6'b000100,
                         OP_BNE   = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101,
                         OP_LUI   = 6'b001111, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_SLT = 3'b100, ALU_LUI = 3'b110,
                         ALU_FN  = 3'b111;

  localparam int CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_reg_dst;
  logic             w_mem_state;
  logic             w_timeout;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  // The counter holds the number of cycles already waited, so the timeout
  // fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
  assign w_timeout   = (MEM_TIMEOUT > 0) && w_mem_state && !mem_ready &&
                       (r_cnt == CNT_W'(TO_LAST));

  // State register, wait counter and latched destination
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_reg_dst <= 2'd0;
    end else begin
      r_state <= w_next;
      // Any state change (including timeout re-entry into FETCH) restarts the count.
      if (w_next != r_state || w_timeout || !w_mem_state) r_cnt <= '0;
      else                                                r_cnt <= r_cnt + 1'b1;
      if (r_state == S_REX)      r_reg_dst <= 2'd1;
      else if (r_state == S_IEX) r_reg_dst <= 2'd0;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                 w_next = (funct == FN_JR) ? S_JR : S_REX;
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_BEQ, OP_BNE:           w_next = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_LUI:  w_next = S_IEX;
          OP_J, OP_JAL:             w_next = S_JUMP;
          default:                  w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMRD);
      S_MEMWR:  w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
      S_REX:    w_next = S_ALUWB;
      S_IEX:    w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pc_we = 1'b0; ir_we = 1'b0; reg_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    iord = 1'b0; ext_sel = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'd0;
    pc_src = 2'd0; reg_dst = 2'd0; mem_to_reg = 2'd0; alu_op = ALU_ADD;
    illegal = 1'b0; bus_error = w_timeout; state = r_state;
    case (r_state)
      S_FETCH: begin
        mem_req = !w_timeout;
        if (mem_ready) begin
          ir_we = 1'b1; pc_we = 1'b1; alu_src_b = 2'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        illegal   = !op_legal(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1; alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        mem_req = !w_timeout; iord = 1'b1;
      end
      S_MEMWB: begin
        reg_we = 1'b1; mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        // An abandoned store must not write, so drop the request on timeout.
        mem_req = !w_timeout; mem_we = !w_timeout; iord = 1'b1;
      end
      S_REX: begin
        alu_src_a = 1'b1; alu_op = ALU_FN;
      end
      S_IEX: begin
        alu_src_a = 1'b1; alu_src_b = 2'd2;
        ext_sel   = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_we = 1'b1; reg_dst = r_reg_dst;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = 2'd1;
        pc_we     = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_src = 2'd2; pc_we = 1'b1;
        if (opcode == OP_JAL) begin
          reg_we = 1'b1; reg_dst = 2'd2; mem_to_reg = 2'd2;
        end
      end
      S_JR: begin
        pc_src = 2'd3; pc_we = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every output, whatever state the register holds.
    if (reset) begin
      pc_we = 1'b0; ir_we = 1'b0; reg_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      iord = 1'b0; ext_sel = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'd0;
      pc_src = 2'd0; reg_dst = 2'd0; mem_to_reg = 2'd0; alu_op = ALU_ADD;
      illegal = 1'b0; bus_error = 1'b0; state = S_FETCH;
    end
  end

endmodule
